// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000 bus target answering a fixed window from a 16-bit register bank.
// Optional macro RESP_BERR_EN adds nBERR_OE to flag accesses to unimplemented offsets.

module m68k_bus_responder #(
   parameter logic [23:0] BASE_ADDR   = 24'hE90000,
   parameter int          WIN_BITS    = 8,
   parameter int          NUM_REGS    = 8,
   parameter int          DTACK_DELAY = 2
) (
   input  logic                sys_clk,
   input  logic                sys_rst,
   input  logic                nAS,
   input  logic                nUDS,
   input  logic                nLDS,
   input  logic                RnW,
   input  logic [23:1]         A,
   input  logic [2:0]          FC,
   input  logic [15:0]         D_IN,
   output logic [15:0]         D_OUT,
   output logic                D_OE,
   output logic                nDTACK_OE,
`ifdef RESP_BERR_EN
   output logic                nBERR_OE,
`endif
   input  logic                host_wr,
   input  logic [WIN_BITS-2:0] host_addr,
   input  logic [15:0]         host_wdata,
   output logic [15:0]         host_rdata,
   output logic                bus_wr_pulse,
   output logic [WIN_BITS-2:0] bus_wr_addr,
   output logic                busy
);

   localparam int         OW  = WIN_BITS - 1;
   localparam logic [3:0] DLY = 4'(DTACK_DELAY);
`ifdef RESP_BERR_EN
   localparam bit BERR = 1'b1;
`else
   localparam bit BERR = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, DECODE, WAIT_DS, DELAY, ACK, RELEASE
   } state_t;

   state_t        state;
   logic [1:0]    as_q, uds_q, lds_q, rnw_q;
   logic [23:1]   a_q1, a_s;
   logic [2:0]    fc_q1, fc_s;
   logic [15:0]   d_q1, d_s;
   logic          as_s, uds_s, lds_s, rnw_s;
   logic [OW-1:0] off_l;
   logic          rnw_l;
   logic [3:0]    cnt;
   logic          stale;
   logic [15:0]   bank [NUM_REGS];
   logic [15:0]   rd_word;
   logic          impl;
   logic          ok;
   logic          sel;
   logic          bus_we;

   // Two-stage synchronizers, unreset so the live bus is tracked through reset
   always_ff @(posedge sys_clk) begin
      as_q  <= {as_q[0], ~nAS};
      uds_q <= {uds_q[0], ~nUDS};
      lds_q <= {lds_q[0], ~nLDS};
      rnw_q <= {rnw_q[0], RnW};
      a_q1  <= A;
      a_s   <= a_q1;
      fc_q1 <= FC;
      fc_s  <= fc_q1;
      d_q1  <= D_IN;
      d_s   <= d_q1;
   end

   assign as_s  = as_q[1];
   assign uds_s = uds_q[1];
   assign lds_s = lds_q[1];
   assign rnw_s = rnw_q[1];

   // Bank lookup at the latched bus offset
   always_comb begin
      rd_word = '0;
      impl    = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (off_l == OW'(i)) begin
            rd_word = bank[i];
            impl    = 1'b1;
         end
      end
   end

   // Host read port, zero outside the implemented words
   always_comb begin
      host_rdata = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (host_addr == OW'(i)) host_rdata = bank[i];
      end
   end

   assign ok  = impl | ~BERR;
   assign sel = as_s & ~stale & (fc_s != 3'b111)
              & (a_s[23:WIN_BITS] == BASE_ADDR[23:WIN_BITS]);
   assign bus_we = (state == DELAY) & (cnt == 4'd0) & ~rnw_l & impl;

   // Register bank: strobed bus lanes override a same-cycle host write
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         for (int i = 0; i < NUM_REGS; i++) bank[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (bus_we && off_l == OW'(i) && uds_s)
               bank[i][15:8] <= d_s[15:8];
            else if (host_wr && host_addr == OW'(i))
               bank[i][15:8] <= host_wdata[15:8];
            if (bus_we && off_l == OW'(i) && lds_s)
               bank[i][7:0] <= d_s[7:0];
            else if (host_wr && host_addr == OW'(i))
               bank[i][7:0] <= host_wdata[7:0];
         end
      end
   end

   // Bus cycle sequencer with registered bus-side outputs
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state        <= IDLE;
         off_l        <= '0;
         rnw_l        <= 1'b1;
         cnt          <= '0;
         stale        <= 1'b1;
         D_OUT        <= '0;
         D_OE         <= 1'b0;
         nDTACK_OE    <= 1'b0;
`ifdef RESP_BERR_EN
         nBERR_OE     <= 1'b0;
`endif
         bus_wr_pulse <= 1'b0;
         bus_wr_addr  <= '0;
         busy         <= 1'b0;
      end else begin
         bus_wr_pulse <= 1'b0;
         stale        <= stale & as_s;
         unique case (state)
            IDLE: begin
               if (sel) begin
                  off_l <= a_s[WIN_BITS-1:1];
                  rnw_l <= rnw_s;
                  busy  <= 1'b1;
                  state <= DECODE;
               end
            end
            DECODE: begin
               if (!as_s) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end else begin
                  if (rnw_l) begin
                     D_OUT <= rd_word;
                     D_OE  <= ok;
                  end
                  state <= WAIT_DS;
               end
            end
            WAIT_DS: begin
               if (!as_s) begin
                  D_OE  <= 1'b0;
                  state <= RELEASE;
               end else if (uds_s || lds_s) begin
                  cnt   <= DLY;
                  state <= DELAY;
               end
            end
            DELAY: begin
               if (cnt == 4'd0) begin
                  if (ok) nDTACK_OE <= 1'b1;
`ifdef RESP_BERR_EN
                  else nBERR_OE <= 1'b1;
`endif
                  if (!rnw_l && ok) begin
                     bus_wr_pulse <= 1'b1;
                     bus_wr_addr  <= off_l;
                  end
                  state <= ACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            ACK: begin
               if (!as_s) begin
                  nDTACK_OE <= 1'b0;
`ifdef RESP_BERR_EN
                  nBERR_OE  <= 1'b0;
`endif
                  D_OE      <= 1'b0;
                  state     <= RELEASE;
               end
            end
            RELEASE: begin
               nDTACK_OE <= 1'b0;
               D_OE      <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: directed bus/host cycles checked against a timeline model.
// Honours RESP_BERR_EN when the design is built with it.

module tb_m68k_bus_responder;

   localparam int D    = 2;
   localparam int HUGE = 1 << 30;
`ifdef RESP_BERR_EN
   localparam bit BERR = 1'b1;
`else
   localparam bit BERR = 1'b0;
`endif

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b1;
   logic        nAS = 1'b1, nUDS = 1'b1, nLDS = 1'b1, RnW = 1'b1;
   logic [23:1] A = '0;
   logic [2:0]  FC = 3'b101;
   logic [15:0] D_IN = '0;
   logic [15:0] D_OUT;
   logic        D_OE, nDTACK_OE, berr;
   logic        host_wr = 1'b0;
   logic [6:0]  host_addr = '0;
   logic [15:0] host_wdata = '0;
   logic [15:0] host_rdata;
   logic        bus_wr_pulse;
   logic [6:0]  bus_wr_addr;
   logic        busy;

   m68k_bus_responder dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS), .RnW(RnW),
      .A(A), .FC(FC), .D_IN(D_IN),
      .D_OUT(D_OUT), .D_OE(D_OE), .nDTACK_OE(nDTACK_OE),
`ifdef RESP_BERR_EN
      .nBERR_OE(berr),
`endif
      .host_wr(host_wr), .host_addr(host_addr),
      .host_wdata(host_wdata), .host_rdata(host_rdata),
      .bus_wr_pulse(bus_wr_pulse), .bus_wr_addr(bus_wr_addr),
      .busy(busy)
   );

`ifndef RESP_BERR_EN
   assign berr = 1'b0;
`endif

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   int errors = 0;
   int checks = 0;
   int pulse_cnt = 0;
   bit chk_en = 1'b0;

   logic [15:0] exp_bank [8];
   logic        m_sel = 1'b0, m_rnw = 1'b1, m_impl = 1'b1;
   logic [6:0]  m_off = '0;
   logic [15:0] m_rdata = '0;
   int t_as = HUGE, t_ds = HUGE, t_rel = HUGE, t_kill = HUGE;

   always @(posedge sys_clk) cyc <= cyc + 1;

   function automatic int imin(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h, want %h", nm, cyc, act, exp);
      end
   endtask

   always @(posedge sys_clk) if (chk_en) begin : pulse_count
      #1;
      if (bus_wr_pulse) pulse_cnt++;
   end

   // Expected outputs from cycle timestamps: sync 2, decode 1, wait 1, delay D+1
   always @(posedge sys_clk) begin : compare
      logic e_ok, e_busy, e_ack, e_berr, e_doe, e_pulse;
      int   end_oe;
      #1;
      if (chk_en) begin
         e_ok    = m_impl || !BERR;
         end_oe  = imin(t_rel + 3, t_kill + 1);
         e_busy  = m_sel && cyc >= t_as + 3 && cyc < imin(t_rel + 4, t_kill + 1);
         e_ack   = m_sel && e_ok && cyc >= t_ds + 4 + D && cyc < end_oe;
         e_berr  = m_sel && !e_ok && cyc >= t_ds + 4 + D && cyc < end_oe;
         e_doe   = m_sel && m_rnw && e_ok && cyc >= t_as + 4 && cyc < end_oe;
         e_pulse = m_sel && !m_rnw && e_ok && cyc == t_ds + 4 + D && cyc <= t_kill;
         chk("busy", 32'(busy), 32'(e_busy));
         chk("dtack", 32'(nDTACK_OE), 32'(e_ack));
         chk("berr", 32'(berr), 32'(e_berr));
         chk("d_oe", 32'(D_OE), 32'(e_doe));
         chk("wr_pulse", 32'(bus_wr_pulse), 32'(e_pulse));
         if (e_doe) chk("d_out", 32'(D_OUT), 32'(m_rdata));
         if (e_pulse) chk("wr_addr", 32'(bus_wr_addr), 32'(m_off));
      end
   end

   task automatic host_write(input logic [6:0] a, input logic [15:0] d);
      @(negedge sys_clk);
      host_addr  = a;
      host_wdata = d;
      host_wr    = 1'b1;
      @(negedge sys_clk);
      host_wr = 1'b0;
      if (a < 7'd8) exp_bank[a[2:0]] = d;
   endtask

   task automatic chk_host(input string nm, input logic [6:0] a, input logic [15:0] e);
      host_addr = a;
      #1;
      chk(nm, 32'(host_rdata), 32'(e));
   endtask

   task automatic bus_cycle(
      input  logic [23:0] addr, input logic [2:0] fc, input logic rnw,
      input  logic u, input logic l, input logic [15:0] wd,
      input  logic hw_en, input logic [6:0] hw_addr, input logic [15:0] hw_data,
      input  logic do_rst, output int lat, output logic [15:0] rd);
      logic acked;
      @(negedge sys_clk);
      m_sel   = (fc != 3'b111) && (addr[23:8] == 16'hE900);
      m_off   = addr[7:1];
      m_rnw   = rnw;
      m_impl  = addr[7:1] < 7'd8;
      m_rdata = m_impl ? exp_bank[addr[3:1]] : 16'h0000;
      t_as = cyc; t_ds = HUGE; t_rel = HUGE; t_kill = HUGE;
      A = addr[23:1]; FC = fc; RnW = rnw; D_IN = wd; nAS = 1'b0;
      repeat (2) @(negedge sys_clk);
      nUDS = !u; nLDS = !l;
      t_ds = cyc;
      if (hw_en) begin
         while (cyc < t_ds + 3 + D) @(negedge sys_clk);
         host_addr  = hw_addr;
         host_wdata = hw_data;
         host_wr    = 1'b1;
         @(negedge sys_clk);
         host_wr = 1'b0;
      end
      acked = 1'b0;
      for (int k = 0; k < 24 && !acked; k++) begin
         if (nDTACK_OE || berr) acked = 1'b1;
         else @(negedge sys_clk);
      end
      lat = cyc - t_ds;
      rd  = D_OUT;
      chk("ack_seen", 32'(acked), 32'(m_sel));
      if (hw_en && hw_addr < 7'd8) exp_bank[hw_addr[2:0]] = hw_data;
      if (m_sel && !rnw && m_impl) begin
         if (u) exp_bank[addr[3:1]][15:8] = wd[15:8];
         if (l) exp_bank[addr[3:1]][7:0]  = wd[7:0];
      end
      if (do_rst) begin
         sys_rst = 1'b1;
         t_kill  = cyc;
         for (int i = 0; i < 8; i++) exp_bank[i] = '0;
         @(negedge sys_clk);
         sys_rst = 1'b0;
         chk("rst_dtack_drop", 32'(nDTACK_OE), 32'd0);
         repeat (10) @(negedge sys_clk);
         chk("stale_as_busy", 32'(busy), 32'd0);
      end
      nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1; RnW = 1'b1;
      t_rel = cyc;
      repeat (6) @(negedge sys_clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int p0;
      logic [15:0] rd;
      for (int i = 0; i < 8; i++) exp_bank[i] = '0;
      repeat (4) @(negedge sys_clk);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("rst_d_oe", 32'(D_OE), 32'd0);
      chk("rst_dtack", 32'(nDTACK_OE), 32'd0);
      chk("rst_d_out", 32'(D_OUT), 32'd0);
      chk("rst_pulse", 32'(bus_wr_pulse), 32'd0);
      chk("rst_wr_addr", 32'(bus_wr_addr), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk_host("rst_bank0", 7'd0, 16'h0000);
      chk_en = 1'b1;

      host_write(7'd3, 16'hA55A);
      chk_host("host_wr3", 7'd3, 16'hA55A);
      bus_cycle(24'hE90006, 3'b101, 1'b1, 1'b1, 1'b1, 16'h0,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
      chk("read3_data", 32'(rd), 32'h0000A55A);
      chk("read3_latency", 32'(lat), 32'd6);

      host_write(7'd2, 16'hFFFF);
      p0 = pulse_cnt;
      bus_cycle(24'hE90004, 3'b101, 1'b0, 1'b1, 1'b0, 16'h1234,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
      chk_host("uds_write2", 7'd2, 16'h12FF);
      chk("uds_write2_pulses", 32'(pulse_cnt - p0), 32'd1);
      chk("uds_write2_addr", 32'(bus_wr_addr), 32'd2);

      bus_cycle(24'hE80000, 3'b101, 1'b1, 1'b1, 1'b1, 16'h0,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
      bus_cycle(24'hE90000, 3'b111, 1'b1, 1'b1, 1'b1, 16'h0,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
      chk("unsel_busy", 32'(busy), 32'd0);

      bus_cycle(24'hE90002, 3'b101, 1'b0, 1'b0, 1'b1, 16'h0011,
                1'b1, 7'd1, 16'hBEEF, 1'b0, lat, rd);
      chk_host("collide1", 7'd1, 16'hBE11);
      chk_host("collide1_model", 7'd1, exp_bank[1]);

      bus_cycle(24'hE90006, 3'b101, 1'b1, 1'b1, 1'b1, 16'h0,
                1'b0, 7'd0, 16'h0, 1'b1, lat, rd);
      chk_host("rst_clears3", 7'd3, 16'h0000);

      bus_cycle(24'hE9000A, 3'b101, 1'b0, 1'b1, 1'b1, 16'h5A5A,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
      bus_cycle(24'hE9000A, 3'b101, 1'b1, 1'b0, 1'b1, 16'h0,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
      chk("byte_read5", 32'(rd), 32'h00005A5A);
      chk_host("host_read5", 7'd5, 16'h5A5A);

      bus_cycle(24'hE90028, 3'b101, 1'b1, 1'b1, 1'b1, 16'h0,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
`ifdef RESP_BERR_EN
      chk("unimpl_read_dtack", 32'(nDTACK_OE), 32'd0);
`else
      chk("unimpl_read_data", 32'(rd), 32'd0);
`endif
      p0 = pulse_cnt;
      bus_cycle(24'hE90028, 3'b101, 1'b0, 1'b1, 1'b1, 16'hCAFE,
                1'b0, 7'd0, 16'h0, 1'b0, lat, rd);
      chk("unimpl_write_pulses", 32'(pulse_cnt - p0), BERR ? 32'd0 : 32'd1);
      chk_host("unimpl_no_alias", 7'd4, 16'h0000);
      host_write(7'd20, 16'h1234);
      chk_host("host_unimpl", 7'd20, 16'h0000);
      chk_host("host_no_alias", 7'd4, 16'h0000);

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- 68000 bus target (slave) on the Amiga bus, run from the FPGA system clock.
- The existing bus initiator issues cycles; this block decodes a fixed address window, answers with DTACK, and serves reads/writes from a small 16-bit register bank.
- The Pi-side register interface can also access the bank, and is notified of each bus write.

Parameters:
BASE_ADDR, 24'hE90000, byte base of window; bits below window size ignored
WIN_BITS, 8, window size = 2^WIN_BITS bytes (word offset = A[WIN_BITS-1:1])
NUM_REGS, 8, implemented words at offsets 0..NUM_REGS-1 (≤ 2^(WIN_BITS-1))
DTACK_DELAY, 2, sys_clk cycles from data-strobe detect to DTACK assertion (0..15)

Ports:
sys_clk  in  1  system clock (PLL), all logic on rising edge
sys_rst  in  1  synchronous active-high reset
nAS  in  1  address strobe (async)
nUDS  in  1  upper data strobe, D[15:8] (async)
nLDS  in  1  lower data strobe, D[7:0] (async)
RnW  in  1  1=read (async)
A  in  23  A[23:1] (async)
FC  in  3  function code; FC==3'b111 (IACK) never selects
D_IN  in  16  bus data in
D_OUT  out  16  read data
D_OE  out  1  drive D_OUT onto bus
nDTACK_OE  out  1  1 = pull DTACK low (open-drain)
host_wr  in  1  one-cycle host write strobe
host_addr  in  WIN_BITS-1  host word offset
host_wdata  in  16  host write data
host_rdata  out  16  bank[host_addr], combinational; 0 if unimplemented
bus_wr_pulse  out  1  one-cycle pulse after bus write committed
bus_wr_addr  out  WIN_BITS-1  offset of last bus write
busy  out  1  1 while not IDLE

Behaviour:
- All bus inputs pass through 2-FF synchronizers. Decisions use synchronized values only.
- Reset values: D_OE=0, nDTACK_OE=0, D_OUT=0, bus_wr_pulse=0, bus_wr_addr=0, busy=0, all bank words=0, state=IDLE.
- sel = as_s & FC!=3'b111 & A[23:WIN_BITS]==BASE_ADDR[23:WIN_BITS].
- FSM states:
  - IDLE: go to DECODE on sel.
  - DECODE: latch offset, RnW, FC. If the latched AS is already deasserted, return to IDLE. Otherwise go to WAIT_DS.
  - WAIT_DS:
    - Wait for uds_s|lds_s.
    - Read: on entry, D_OUT=bank word (0 if offset ≥ NUM_REGS) and D_OE=1.
    - When a strobe is seen, load the delay counter with DTACK_DELAY and go to DELAY.
    - If AS deasserts before any strobe, go to RELEASE.
  - DELAY:
    - Count down to 0, then go to ACK.
    - Write: on the last DELAY cycle, sample synchronized D_IN into the enabled lanes only. UDS writes [15:8], LDS writes [7:0].
    - Writes to offset ≥ NUM_REGS are discarded.
  - ACK:
    - nDTACK_OE=1, held until as_s=0, then go to RELEASE.
    - For a write, bus_wr_pulse=1 for exactly one cycle on ACK entry, with bus_wr_addr=offset, even when discarded.
  - RELEASE: nDTACK_OE=0, D_OE=0 in the same cycle, then IDLE. A new sel is not honoured until IDLE (one cycle minimum gap).
- Latency: DTACK is asserted 2 (sync) + 1 + DTACK_DELAY + 1 cycles after the strobe edge.
- Host/bus write to the same word in the same cycle: the bus byte lanes win, and the host value lands in the non-strobed lanes.
- Host writes to offset ≥ NUM_REGS are ignored.
- sys_rst mid-cycle: outputs drop immediately at the next edge and the FSM goes to IDLE. An AS still asserted after reset is ignored until it deasserts (no re-decode of a stale cycle).
- Byte read (single strobe): the full word is driven; the initiator selects the lane.

Optional Feature:
- Macro RESP_BERR_EN.
- Defined:
  - Adds output nBERR_OE (1 = pull BERR low).
  - An access to offset ≥ NUM_REGS asserts nBERR_OE instead of nDTACK_OE, with the same timing and release rules.
  - D_OE stays 0 for such reads, and no bus_wr_pulse is generated.
- Undefined: port absent; unimplemented offsets DTACK normally, reads return 0, writes are discarded (pulse still fires).

Test Plan:
1. Host writes 16'hA55A at offset 3; bus word read at E90006 -> D_OUT=A55A, D_OE=1 before DTACK, nDTACK_OE rises 4+DTACK_DELAY cycles after strobe, drops with D_OE one cycle after AS release.
2. Bus write 16'h1234 with nUDS only at E90004 over 16'hFFFF -> bank[2]=12FF, bus_wr_pulse single cycle, bus_wr_addr=2.
3. Access at E80000, and a FC=3'b111 cycle at E90000 -> nDTACK_OE and D_OE stay 0, busy stays 0 after sync.
4. Simultaneous host write 16'hBEEF and bus LDS write 16'h0011 to offset 1 -> bank[1]=BE11.
5. Assert sys_rst during ACK with AS still low -> nDTACK_OE=0 next edge; AS held 10 more cycles -> no re-acknowledge; next full cycle acknowledged normally.
6. RESP_BERR_EN: read at offset 20 (E90028) -> nBERR_OE asserted, nDTACK_OE=0, D_OE=0; without macro, same access -> DTACK with D_OUT=0.
